// File: rtl/tx_pkg.sv
// Shared types and constants for the TX nibble scheduler.
//   NIBS   - nibbles per buffered word
//   WORD_W - buffered word width
//   NIB_W  - nibble width
//   state_t - scheduler state encoding
package tx_pkg;

    localparam int unsigned NIBS   = 6;
    localparam int unsigned WORD_W = 24;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned REQ_N  = 2;
    localparam int unsigned GAP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, reset - clock, synchronous active-high reset
//   req        - request vector
//   en         - grant window; gnt is zero outside it
//   upd        - strobe: remember the current grant as last winner
//   gnt        - one-hot (or zero) grant, combinational
module rr_arb2
    import tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_N-1:0] req,
    input  logic             en,
    input  logic             upd,
    output logic [REQ_N-1:0] gnt
);

    // Index of the last requester granted; starts at 1 so requester 0 wins first.
    logic rr_last;

    // Grant selection: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        gnt = '0;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    // Round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (upd) begin
            rr_last <= gnt[1];
        end
    end

endmodule

// File: rtl/nibble_tx_sched.sv
// Scheduler in front of the 24-bit-to-nibble serialising buffer.
// Arbitrates two word requesters, issues the buffer load pulse and tags
// the six nibble cycles that follow for the symbol mapper.
//   clk, reset  - clock, synchronous active-high reset
//   tx_en       - enables new grants; the word in flight always completes
//   req_valid   - per-requester word valid
//   req_word    - {word1, word0}
//   req_ready   - per-requester accept (combinational, one-hot or zero)
//   buf_enable  - buffer load pulse
//   buf_word    - word to load, zero when buf_enable is low
//   nib_valid   - buffer output holds a fresh nibble
//   nib_first   - nibble is bits [23:20]
//   nib_last    - nibble is bits [3:0]
//   nib_src     - requester index of the word being shifted
//   busy        - load, word in flight or gap running
module nibble_tx_sched #(
    parameter int unsigned GAP  = 0,
    parameter int unsigned NIBS = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tx_en,
    input  logic [tx_pkg::REQ_N-1:0]          req_valid,
    input  logic [2*tx_pkg::WORD_W-1:0]       req_word,
    output logic [tx_pkg::REQ_N-1:0]          req_ready,
    output logic                              buf_enable,
    output logic [tx_pkg::WORD_W-1:0]         buf_word,
    output logic                              nib_valid,
    output logic                              nib_first,
    output logic                              nib_last,
    output logic                              nib_src,
    output logic                              busy
);

    import tx_pkg::*;

    localparam int unsigned CNT_W = $clog2(NIBS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gcnt;
    logic             src_q;

    logic             can_load;
    logic [REQ_N-1:0] gnt;
    logic             grant;
    logic             gsel;

    // Load opportunity; reset suppresses any grant in the same cycle.
    always_comb begin
        can_load = 1'b0;
        if (tx_en && !reset) begin
            unique case (state)
                ST_IDLE:  can_load = 1'b1;
                ST_SHIFT: can_load = (cnt == '0) && (GAP == 0);
                ST_GAP:   can_load = (gcnt == '0);
                default:  can_load = 1'b0;
            endcase
        end
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (can_load),
        .upd   (grant),
        .gnt   (gnt)
    );

    assign grant = |gnt;
    assign gsel  = gnt[1];

    // Handshake and load are same-cycle with the grant.
    assign req_ready  = gnt;
    assign buf_enable = grant;
    assign buf_word   = !grant ? '0 :
                        gsel   ? req_word[2*WORD_W-1:WORD_W] : req_word[WORD_W-1:0];

    // Nibble tags decode directly from registered state.
    assign nib_valid = (state == ST_SHIFT);
    assign nib_first = (state == ST_SHIFT) && (cnt == CNT_W'(NIBS - 1));
    assign nib_last  = (state == ST_SHIFT) && (cnt == '0);
    assign nib_src   = src_q;
    assign busy      = (state != ST_IDLE) || grant;

    // State machine and nibble / gap counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= CNT_W'(NIBS - 1);
            gcnt  <= '0;
            src_q <= 1'b0;
        end else if (grant) begin
            state <= ST_SHIFT;
            cnt   <= CNT_W'(NIBS - 1);
            src_q <= gsel;
        end else begin
            unique case (state)
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (GAP > 0) begin
                        state <= ST_GAP;
                        gcnt  <= GAP_W'(GAP - 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gcnt != '0) begin
                        gcnt <= gcnt - GAP_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_tx_sched.sv
// Directed bench for nibble_tx_sched: one instance with GAP=0, one with GAP=3,
// plus a reference nibble buffer fed by the GAP=0 instance's load pulse.
module tb_nibble_tx_sched;

    logic        clk;
    logic        reset;
    logic        tx_en;

    logic [1:0]  a_valid;
    logic [47:0] a_word;
    logic [1:0]  a_ready;
    logic        a_en;
    logic [23:0] a_bword;
    logic        a_nv, a_nf, a_nl, a_src, a_busy;

    logic [1:0]  b_valid;
    logic [47:0] b_word;
    logic [1:0]  b_ready;
    logic        b_en;
    logic [23:0] b_bword;
    logic        b_nv, b_nf, b_nl, b_src, b_busy;

    int checks   = 0;
    int failures = 0;

    nibble_tx_sched #(.GAP(0), .NIBS(6)) dut0 (
        .clk(clk), .reset(reset), .tx_en(tx_en),
        .req_valid(a_valid), .req_word(a_word), .req_ready(a_ready),
        .buf_enable(a_en), .buf_word(a_bword),
        .nib_valid(a_nv), .nib_first(a_nf), .nib_last(a_nl), .nib_src(a_src),
        .busy(a_busy)
    );

    nibble_tx_sched #(.GAP(3), .NIBS(6)) dut3 (
        .clk(clk), .reset(reset), .tx_en(tx_en),
        .req_valid(b_valid), .req_word(b_word), .req_ready(b_ready),
        .buf_enable(b_en), .buf_word(b_bword),
        .nib_valid(b_nv), .nib_first(b_nf), .nib_last(b_nl), .nib_src(b_src),
        .busy(b_busy)
    );

    // Reference serialising buffer: presents store[idx], idx 5 down to 0 after a load.
    logic [23:0] bstore;
    int          bidx;
    logic [3:0]  bnib;
    always @(posedge clk) begin
        if (reset) begin
            bstore <= '0;
            bidx   <= 0;
        end else if (a_en) begin
            bstore <= a_bword;
            bidx   <= 5;
        end else if (bidx != 0) begin
            bidx <= bidx - 1;
        end
    end
    assign bnib = bstore[bidx*4 +: 4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] w;
        reset   = 1'b1;
        tx_en   = 1'b0;
        a_valid = '0;
        a_word  = '0;
        b_valid = '0;
        b_word  = '0;
        cyc();
        cyc();

        // Reset state
        check("rst ready",  32'(a_ready), 32'(0));
        check("rst en",     32'(a_en),    32'(0));
        check("rst bword",  32'(a_bword), 32'(0));
        check("rst nv",     32'(a_nv),    32'(0));
        check("rst busy",   32'(a_busy),  32'(0));
        check("rst src",    32'(a_src),   32'(0));
        reset = 1'b0;
        cyc();

        // Single word, GAP=0
        tx_en  = 1'b1;
        a_word = {24'h000000, 24'hABCDEF};
        w      = 24'hABCDEF;
        for (int c = 0; c <= 8; c++) begin
            a_valid = (c == 0) ? 2'b01 : 2'b00;
            #1;
            check($sformatf("t1 ready c%0d", c), 32'(a_ready), (c == 0) ? 32'h1 : 32'h0);
            check($sformatf("t1 bword c%0d", c), 32'(a_bword), (c == 0) ? 32'hABCDEF : 32'h0);
            check($sformatf("t1 nv c%0d", c),    32'(a_nv),    32'(c >= 1 && c <= 6));
            check($sformatf("t1 first c%0d", c), 32'(a_nf),    32'(c == 1));
            check($sformatf("t1 last c%0d", c),  32'(a_nl),    32'(c == 6));
            check($sformatf("t1 busy c%0d", c),  32'(a_busy),  32'(c <= 6));
            if (c >= 1 && c <= 6) begin
                check($sformatf("t1 nib c%0d", c), 32'(bnib), 32'(w[(6-c)*4 +: 4]));
                check($sformatf("t1 src c%0d", c), 32'(a_src), 32'(0));
            end
            cyc();
        end

        // Back-to-back contention, GAP=0
        do_reset();
        a_word  = {24'h222222, 24'h111111};
        a_valid = 2'b11;
        for (int c = 0; c <= 24; c++) begin
            #1;
            if (c % 6 == 0) begin
                check($sformatf("t2 ready c%0d", c), 32'(a_ready), ((c / 6) % 2 == 1) ? 32'h2 : 32'h1);
                check($sformatf("t2 bword c%0d", c), 32'(a_bword), ((c / 6) % 2 == 1) ? 32'h222222 : 32'h111111);
            end else begin
                check($sformatf("t2 ready c%0d", c), 32'(a_ready), 32'h0);
            end
            check($sformatf("t2 nv c%0d", c), 32'(a_nv), 32'(c >= 1));
            if (c >= 1) begin
                check($sformatf("t2 src c%0d", c), 32'(a_src), 32'(((c - 1) / 6) % 2));
            end
            cyc();
        end
        a_valid = 2'b00;

        // GAP=3, requester 1 only
        do_reset();
        b_word = {24'h123456, 24'h000000};
        for (int c = 0; c <= 19; c++) begin
            b_valid = (c <= 15) ? 2'b10 : 2'b00;
            #1;
            check($sformatf("t3 ready c%0d", c), 32'(b_ready), (c == 0 || c == 9) ? 32'h2 : 32'h0);
            check($sformatf("t3 nv c%0d", c), 32'(b_nv), 32'((c >= 1 && c <= 6) || (c >= 10 && c <= 15)));
            check($sformatf("t3 busy c%0d", c), 32'(b_busy), 32'(c <= 18));
            if (c == 10) begin
                check("t3 first c10", 32'(b_nf), 32'(1));
                check("t3 src c10", 32'(b_src), 32'(1));
            end
            cyc();
        end
        b_valid = 2'b00;

        // Reset beats a simultaneous load opportunity; tx_en gating
        reset   = 1'b1;
        tx_en   = 1'b1;
        a_valid = 2'b11;
        #1;
        check("t4 rst ready", 32'(a_ready), 32'h0);
        check("t4 rst en",    32'(a_en),    32'h0);
        cyc();
        reset = 1'b0;
        tx_en = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            #1;
            check($sformatf("t4 ready c%0d", c), 32'(a_ready), 32'h0);
            check($sformatf("t4 busy c%0d", c),  32'(a_busy),  32'h0);
            cyc();
        end
        tx_en = 1'b1;
        #1;
        check("t4 ready c10", 32'(a_ready), 32'h1);
        cyc();
        a_valid = 2'b00;

        // tx_en drops at cycle 3 of a word
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            a_valid = (c == 0) ? 2'b01 : ((c >= 3) ? 2'b11 : 2'b00);
            tx_en   = (c < 3) || (c == 13);
            #1;
            if (c == 13) begin
                check("t5 ready c13", 32'(a_ready), 32'h2);
            end else begin
                check($sformatf("t5 ready c%0d", c), 32'(a_ready), (c == 0) ? 32'h1 : 32'h0);
            end
            check($sformatf("t5 nv c%0d", c),   32'(a_nv), 32'(c >= 1 && c <= 6));
            check($sformatf("t5 last c%0d", c), 32'(a_nl), 32'(c == 6));
            cyc();
        end
        a_valid = 2'b00;
        tx_en   = 1'b1;
        cyc();

        // Reset at cycle 3 of a word
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            a_valid = (c == 0) ? 2'b01 : ((c == 5) ? 2'b11 : 2'b00);
            reset   = (c == 3);
            #1;
            if (c == 0) check("t6 ready c0", 32'(a_ready), 32'h1);
            if (c >= 1 && c <= 3) check($sformatf("t6 nv c%0d", c), 32'(a_nv), 32'h1);
            if (c == 4) begin
                check("t6 nv c4",    32'(a_nv),    32'h0);
                check("t6 first c4", 32'(a_nf),    32'h0);
                check("t6 last c4",  32'(a_nl),    32'h0);
                check("t6 src c4",   32'(a_src),   32'h0);
                check("t6 busy c4",  32'(a_busy),  32'h0);
                check("t6 ready c4", 32'(a_ready), 32'h0);
                check("t6 en c4",    32'(a_en),    32'h0);
                check("t6 bword c4", 32'(a_bword), 32'h0);
            end
            if (c == 5) check("t6 ready c5", 32'(a_ready), 32'h1);
            cyc();
        end
        reset   = 1'b0;
        a_valid = 2'b00;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
